pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage 16-bit pipeline. It drives the write enables and bubble-insert (flush) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, instruction/data memory busy stalls, taken-branch squashes and halt drain. A 3-state FSM sequences halt, and a saturating counter records stall cycles.

## Interface
- (no parameters)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs, id_rt  in  4 each  source register numbers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads Rs / Rt
- id_halt  in  1  instruction in ID is HLT
- ex_memread  in  1  instruction in EX is a load
- ex_rd  in  4  destination register of the instruction in EX
- br_taken  in  1  branch resolved taken in ID; held high until a cycle with pc_wen=1
- imem_busy  in  1  instruction memory has not returned the fetch this cycle
- dmem_busy  in  1  data memory access in MEM not complete this cycle
- pc_wen  out  1  PC register write enable
- ifid_wen, idex_wen, exmem_wen, memwb_wen  out  1 each  pipeline register write enables
- ifid_flush, idex_flush  out  1 each  load NOP/bubble (all control bits 0) instead of d; only meaningful when the matching wen=1
- halted  out  1  processor fully halted
- stall_cycles  out  16  saturating count of RUN/DRAIN cycles with pc_wen=0

## Operation
- luse = ex_memread & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- FSM states: RUN (reset), DRAIN, HALTED.
- RUN decode, in strict priority order; the first matching rule applies:
  1. dmem_busy: all five wen=0, both flushes=0 (whole pipe frozen).
  2. luse: pc_wen=0, ifid_wen=0, idex_wen=1 with idex_flush=1, exmem_wen=1, memwb_wen=1.
  3. br_taken & !imem_busy: all wen=1, ifid_flush=1 (squash wrong-path fetch).
  4. imem_busy: pc_wen=0, ifid_wen=1 with ifid_flush=1, others wen=1. A pending br_taken stays asserted by its source and is taken in the first cycle imem_busy=0.
  5. Otherwise: all wen=1, no flush.
- Halt acceptance: id_halt & !dmem_busy & !luse in RUN.
  - That cycle: pc_wen=0, ifid_wen=1 with ifid_flush=1, idex_wen=1 (HLT advances).
  - At the clock edge: go to DRAIN and load drain_cnt=3.
- DRAIN behaviour:
  - pc_wen=0 and ifid_wen=1/ifid_flush=1 every cycle.
  - Downstream wen follows the dmem_busy freeze rule.
  - luse and br_taken are ignored, since only bubbles sit behind HLT.
  - drain_cnt decrements on each cycle with dmem_busy=0.
  - When drain_cnt==1 and dmem_busy=0, go to HALTED at the clock edge.
- HALTED: all wen=0, flushes 0, halted=1; absorbing until rst_n.
- stall_cycles increments by 1 on each clock edge where the state is RUN or DRAIN and pc_wen=0. It saturates at 16'hFFFF and is not incremented in HALTED.

## Timing
- All wen/flush outputs are combinational from the current inputs and state; there is no added latency.
- State, drain_cnt, halted and stall_cycles are registered on the rising clk edge.
- halted is registered: it rises the cycle after the DRAIN→HALTED edge and never drops until reset.
- Load-use costs exactly one bubble when dmem_busy=0.
- Taken branch costs one squashed slot.
- HLT accepted in cycle T with no dmem stalls:
  - DRAIN during T+1..T+3.
  - HALTED from T+4.
  - Each dmem_busy cycle delays HALTED by one.
- Reset: while rst_n=0, and in the first cycle after release until the state register's value takes effect, state=RUN, drain_cnt=0, stall_cycles=0, halted=0. While rst_n=0, all wen=0 and flushes=0. Reset asserted mid-DRAIN returns to RUN immediately (asynchronously).
- Simultaneous events:
  - dmem_busy with luse/br_taken/imem_busy/id_halt: only the freeze applies; nothing is consumed, so held inputs re-evaluate next cycle.
  - luse with br_taken: the stall wins, and br_taken stays held by its source.

## Test plan
- ex_memread=1, ex_rd=5, id_uses_rs=1, id_rs=5 for one cycle -> pc_wen=0, ifid_wen=0, idex_flush=1, exmem_wen=1; stall_cycles 0→1. Repeat with ex_rd=0 -> no stall.
- dmem_busy=1 for 4 cycles together with luse and br_taken -> all wen=0 for 4 cycles; the next cycle shows the luse stall; stall_cycles +5.
- br_taken=1 while imem_busy=1 for 2 cycles -> pc_wen=0, ifid_flush=1; the third cycle (imem_busy=0) shows pc_wen=1, ifid_flush=1; br_taken then dropped.
- id_halt=1 at cycle T, no other events -> DRAIN T+1..T+3, halted=1 observed from T+5 (registered), all wen=0 from T+4. Then rst_n=0 -> halted=0 and stall_cycles=0 immediately.
- id_halt with dmem_busy pulsed 2 cycles during DRAIN -> HALTED reached at T+6. id_halt with luse asserted -> halt not accepted until luse clears.
- Force stall_cycles to 16'hFFFE via 65534 luse cycles, then 3 more -> holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between pipeline status sources
// and the stall/flush sequencer.
interface pipe_hazard_ctrl_if;
  logic [3:0]  id_rs;
  logic [3:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_halt;
  logic        ex_memread;
  logic [3:0]  ex_rd;
  logic        br_taken;
  logic        imem_busy;
  logic        dmem_busy;
  logic        pc_wen;
  logic        ifid_wen;
  logic        idex_wen;
  logic        exmem_wen;
  logic        memwb_wen;
  logic        ifid_flush;
  logic        idex_flush;
  logic        halted;
  logic [15:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output id_halt, ex_memread, ex_rd,
    output br_taken, imem_busy, dmem_busy,
    input  pc_wen, ifid_wen, idex_wen,
    input  exmem_wen, memwb_wen,
    input  ifid_flush, idex_flush,
    input  halted, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  id_halt, ex_memread, ex_rd,
    input  br_taken, imem_busy, dmem_busy,
    output pc_wen, ifid_wen, idex_wen,
    output exmem_wen, memwb_wen,
    output ifid_flush, idex_flush,
    output halted, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline:
// load-use, memory busy, branch squash and halt drain.
module pipe_hazard_ctrl (
  input logic clk,
  input logic rst_n,
  pipe_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {
    RUN, DRAIN, HALTED
  } state_t;

  state_t      state;
  logic [1:0]  drain_cnt;
  logic        halted_q;
  logic [15:0] stall_q;

  logic luse;
  logic rs_hit;
  logic rt_hit;
  logic halt_acc;
  logic pc_wen;
  logic ifid_wen;
  logic idex_wen;
  logic exmem_wen;
  logic memwb_wen;
  logic ifid_flush;
  logic idex_flush;

  always_comb begin
    rs_hit = hz.id_uses_rs
           & (hz.id_rs == hz.ex_rd);
    rt_hit = hz.id_uses_rt
           & (hz.id_rt == hz.ex_rd);
    luse   = hz.ex_memread
           & (hz.ex_rd != 4'd0)
           & (rs_hit | rt_hit);
    halt_acc = (state == RUN)
             & hz.id_halt
             & ~hz.dmem_busy
             & ~luse;
  end

  always_comb begin
    pc_wen     = 1'b0;
    ifid_wen   = 1'b0;
    idex_wen   = 1'b0;
    exmem_wen  = 1'b0;
    memwb_wen  = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst_n) begin
      unique case (state)
        RUN: begin
          // overlapping events resolve by priority
          priority case (1'b1)
            hz.dmem_busy: ;
            luse: begin
              idex_wen   = 1'b1;
              idex_flush = 1'b1;
              exmem_wen  = 1'b1;
              memwb_wen  = 1'b1;
            end
            halt_acc,
            hz.imem_busy: begin
              ifid_wen   = 1'b1;
              ifid_flush = 1'b1;
              idex_wen   = 1'b1;
              exmem_wen  = 1'b1;
              memwb_wen  = 1'b1;
            end
            hz.br_taken: begin
              pc_wen     = 1'b1;
              ifid_wen   = 1'b1;
              ifid_flush = 1'b1;
              idex_wen   = 1'b1;
              exmem_wen  = 1'b1;
              memwb_wen  = 1'b1;
            end
            default: begin
              pc_wen    = 1'b1;
              ifid_wen  = 1'b1;
              idex_wen  = 1'b1;
              exmem_wen = 1'b1;
              memwb_wen = 1'b1;
            end
          endcase
        end
        DRAIN: begin
          ifid_wen   = 1'b1;
          ifid_flush = 1'b1;
          idex_wen   = ~hz.dmem_busy;
          exmem_wen  = ~hz.dmem_busy;
          memwb_wen  = ~hz.dmem_busy;
        end
        HALTED: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      halted_q  <= 1'b0;
      stall_q   <= 16'd0;
    end else begin
      halted_q <= (state == HALTED);
      if (state != HALTED && !pc_wen
          && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      unique case (state)
        RUN: begin
          if (halt_acc) begin
            state     <= DRAIN;
            drain_cnt <= 2'd3;
          end
        end
        DRAIN: begin
          if (!hz.dmem_busy) begin
            drain_cnt <= drain_cnt - 2'd1;
            if (drain_cnt == 2'd1)
              state <= HALTED;
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

  assign hz.pc_wen       = pc_wen;
  assign hz.ifid_wen     = ifid_wen;
  assign hz.idex_wen     = idex_wen;
  assign hz.exmem_wen    = exmem_wen;
  assign hz.memwb_wen    = memwb_wen;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_flush   = idex_flush;
  assign hz.halted       = halted_q;
  assign hz.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for the pipeline
// stall/flush sequencer.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic rst_n;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl}
  localparam logic [6:0] C_ALL  = 7'b11111_00;
  localparam logic [6:0] C_FRZ  = 7'b00000_00;
  localparam logic [6:0] C_LUSE = 7'b00111_01;
  localparam logic [6:0] C_BR   = 7'b11111_10;
  localparam logic [6:0] C_IMB  = 7'b01111_10;
  localparam logic [6:0] C_DRN  = 7'b01111_10;
  localparam logic [6:0] C_DRNB = 7'b01000_10;

  typedef struct {
    string       tag;
    logic [6:0]  ctl;
    logic        hlt;
    logic [15:0] stl;
  } exp_t;

  exp_t sb[$];
  int   n_run;
  int   n_fail;

  task automatic drive(
    input logic [3:0] rs, input logic urs,
    input logic hlt, input logic mrd,
    input logic [3:0] rd, input logic br,
    input logic ib, input logic db
  );
    hz.id_rs      = rs;
    hz.id_rt      = 4'd0;
    hz.id_uses_rs = urs;
    hz.id_uses_rt = 1'b0;
    hz.id_halt    = hlt;
    hz.ex_memread = mrd;
    hz.ex_rd      = rd;
    hz.br_taken   = br;
    hz.imem_busy  = ib;
    hz.dmem_busy  = db;
  endtask

  task automatic idle();
    drive(4'd0, 1'b0, 1'b0, 1'b0,
          4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string tg, input logic [6:0] c,
    input logic h, input logic [15:0] s
  );
    exp_t e;
    exp_t g;
    logic [6:0] obs;
    e.tag = tg;
    e.ctl = c;
    e.hlt = h;
    e.stl = s;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    obs = {hz.pc_wen, hz.ifid_wen, hz.idex_wen,
           hz.exmem_wen, hz.memwb_wen,
           hz.ifid_flush, hz.idex_flush};
    n_run++;
    assert (obs === g.ctl) else begin
      n_fail++;
      $error("FAIL %s ctl obs=%b exp=%b",
             g.tag, obs, g.ctl);
    end
    n_run++;
    assert (hz.halted === g.hlt) else begin
      n_fail++;
      $error("FAIL %s halted obs=%b exp=%b",
             g.tag, hz.halted, g.hlt);
    end
    n_run++;
    assert (hz.stall_cycles === g.stl) else begin
      n_fail++;
      $error("FAIL %s stall obs=%h exp=%h",
             g.tag, hz.stall_cycles, g.stl);
    end
    tick();
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle();
    tick();
    chk("rst", C_FRZ, 1'b0, 16'd0);
    rst_n = 1'b1;
    chk("idle0", C_ALL, 1'b0, 16'd0);

    // load-use, then same with r0
    drive(4'd5, 1'b1, 1'b0, 1'b1,
          4'd5, 1'b0, 1'b0, 1'b0);
    chk("luse", C_LUSE, 1'b0, 16'd0);
    idle();
    chk("idle1", C_ALL, 1'b0, 16'd1);
    drive(4'd0, 1'b1, 1'b0, 1'b1,
          4'd0, 1'b0, 1'b0, 1'b0);
    chk("luse_r0", C_ALL, 1'b0, 16'd1);

    // dmem freeze beats luse and branch
    for (int i = 0; i < 4; i++) begin
      drive(4'd5, 1'b1, 1'b0, 1'b1,
            4'd5, 1'b1, 1'b0, 1'b1);
      chk("dfrz", C_FRZ, 1'b0, 16'(1 + i));
    end
    drive(4'd5, 1'b1, 1'b0, 1'b1,
          4'd5, 1'b1, 1'b0, 1'b0);
    chk("luse_br", C_LUSE, 1'b0, 16'd5);
    drive(4'd0, 1'b0, 1'b0, 1'b0,
          4'd0, 1'b1, 1'b0, 1'b0);
    chk("br", C_BR, 1'b0, 16'd6);

    // branch held across imem busy
    drive(4'd0, 1'b0, 1'b0, 1'b0,
          4'd0, 1'b1, 1'b1, 1'b0);
    chk("br_imb0", C_IMB, 1'b0, 16'd6);
    chk("br_imb1", C_IMB, 1'b0, 16'd7);
    drive(4'd0, 1'b0, 1'b0, 1'b0,
          4'd0, 1'b1, 1'b0, 1'b0);
    chk("br_go", C_BR, 1'b0, 16'd8);
    idle();
    chk("idle2", C_ALL, 1'b0, 16'd8);

    // halt blocked by luse, then accepted
    drive(4'd5, 1'b1, 1'b1, 1'b1,
          4'd5, 1'b0, 1'b0, 1'b0);
    chk("hlt_luse", C_LUSE, 1'b0, 16'd8);
    drive(4'd0, 1'b0, 1'b1, 1'b0,
          4'd0, 1'b0, 1'b0, 1'b0);
    chk("hlt_T", C_IMB, 1'b0, 16'd9);
    idle();
    chk("drn1", C_DRN, 1'b0, 16'd10);
    chk("drn2", C_DRN, 1'b0, 16'd11);
    chk("drn3", C_DRN, 1'b0, 16'd12);
    chk("hltd4", C_FRZ, 1'b0, 16'd13);
    drive(4'd5, 1'b1, 1'b0, 1'b1,
          4'd5, 1'b1, 1'b0, 1'b0);
    chk("hltd5", C_FRZ, 1'b1, 16'd13);
    chk("hltd6", C_FRZ, 1'b1, 16'd13);

    // async reset out of HALTED
    idle();
    rst_n = 1'b0;
    chk("rst2", C_FRZ, 1'b0, 16'd0);
    rst_n = 1'b1;
    chk("idle3", C_ALL, 1'b0, 16'd0);

    // halt with two dmem stalls in DRAIN
    drive(4'd0, 1'b0, 1'b1, 1'b0,
          4'd0, 1'b0, 1'b0, 1'b0);
    chk("h2_T", C_IMB, 1'b0, 16'd0);
    drive(4'd0, 1'b0, 1'b0, 1'b0,
          4'd0, 1'b0, 1'b0, 1'b1);
    chk("h2_b1", C_DRNB, 1'b0, 16'd1);
    chk("h2_b2", C_DRNB, 1'b0, 16'd2);
    idle();
    chk("h2_d3", C_DRN, 1'b0, 16'd3);
    chk("h2_d4", C_DRN, 1'b0, 16'd4);
    chk("h2_d5", C_DRN, 1'b0, 16'd5);
    chk("h2_T6", C_FRZ, 1'b0, 16'd6);
    chk("h2_T7", C_FRZ, 1'b1, 16'd6);

    // saturation of the stall counter
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(4'd5, 1'b1, 1'b0, 1'b1,
          4'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat0", C_LUSE, 1'b0, 16'hFFFE);
    chk("sat1", C_LUSE, 1'b0, 16'hFFFF);
    chk("sat2", C_LUSE, 1'b0, 16'hFFFF);
    idle();
    chk("sat3", C_ALL, 1'b0, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end
endmodule
